// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: types for the two-port ALU sharing arbiter
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t PORT0 = 1'b0;
    localparam req_id_t PORT1 = 1'b1;

endpackage

// File: rtl/alu_op_pkg.sv
// alu_op_pkg: operation encoding shared by the integer ALU and its clients
package alu_op_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational integer ALU; unknown op codes produce zero
module alu
    import alu_op_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: two-way grant picker, round-robin or fixed priority to port 0
module alu_rr_pick
    import alu_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output req_id_t grant
);

    // A lone valid wins outright; a tie goes to the port that did not win last time
    assign grant = (valid0 & valid1) ? ((PRIO_MODE != 0) ? PORT0 : ~last_grant) : valid1;

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with valid/ready handshakes
// and returns each registered result only to the port that issued it.
module alu_share_arbiter
    import alu_op_pkg::*;
    import alu_arb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  alu_op_t         req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  alu_op_t         req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_zero,
    output logic            busy
);

    arb_state_t      state, next_state;
    req_id_t         last_grant, grant, owner;
    alu_op_t         op_q;
    logic [XLEN-1:0] a_q, b_q, alu_y;
    logic            alu_zero, rsp_fire, slot_free, accept;

    alu_rr_pick #(
        .PRIO_MODE(PRIO_MODE)
    ) u_pick (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .last_grant(last_grant),
        .grant     (grant)
    );

    alu u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y),
        .zero(alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = flush ? IDLE :
                     accept ? EXEC :
                     (state == EXEC) ? RESP :
                     (state == RESP && !rsp_fire) ? RESP : IDLE;
    end

    // A slot opens when idle or when the current owner drains its result this cycle
    always_comb begin
        rsp0_valid = (state == RESP) & (owner == PORT0);
        rsp1_valid = (state == RESP) & (owner == PORT1);
        rsp_fire   = (owner == PORT1) ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
        slot_free  = ((state == IDLE) | rsp_fire) & ~flush;
        accept     = slot_free & (req0_valid | req1_valid);
        req0_ready = accept & (grant == PORT0);
        req1_ready = accept & (grant == PORT1);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT1;
            owner      <= PORT0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                owner      <= grant;
                op_q       <= (grant == PORT1) ? req1_op : req0_op;
                a_q        <= (grant == PORT1) ? req1_a : req0_a;
                b_q        <= (grant == PORT1) ? req1_b : req0_b;
            end
            if (state == EXEC && !flush) begin
                rsp_data <= alu_y;
                rsp_zero <= alu_zero;
            end
        end
    end

endmodule
